// File: rtl/arith_extend_pkg.sv
// arith_extend_pkg: shared types for the extender (sign-mode enum, control bundle and its accessors)
`ifndef ARITH_EXTEND_PKG_SV
`define ARITH_EXTEND_PKG_SV
`define CTRL_CLOCK(c) c.clock
`define CTRL_RESET(c) c.reset
package Arith_pkg;
    typedef enum logic {
        Unsigned = 1'b0,
        Signed   = 1'b1
    } SignedUnsigned;
endpackage
package Util_pkg;
    typedef struct packed {
        logic clock;
        logic reset;
    } Control;
endpackage
`endif

// File: rtl/arith_extend_lane.sv
// arith_extend_lane: one combinational lane that widens IN_W bits to OUT_W bits by sign or zero fill
module arith_extend_lane
    import Arith_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]  in,
    input  SignedUnsigned    sign,
    output logic [OUT_W-1:0] ext
);
    if (OUT_W == IN_W) begin : g_same
        assign ext = in;
    end else begin : g_wide
        assign ext = {{(OUT_W-IN_W){sign == Signed && in[IN_W-1]}}, in};
    end
endmodule

// File: rtl/arith_extend.sv
// arith_extend: DEPTH-lane registered sign/zero extender; define ARITH_EXTEND_BYPASS_EN for a combinational, reset-free version
module arith_extend
    import Arith_pkg::*, Util_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int DEPTH = 1
) (
    input  Control           ctrl,
    input  logic [IN_W-1:0]  in  [DEPTH-1:0],
    input  SignedUnsigned    sign,
    output logic [OUT_W-1:0] out [DEPTH-1:0]
);
    logic [OUT_W-1:0] ext [DEPTH-1:0];
    if (OUT_W < IN_W) begin : g_bad_width
        $error("arith_extend: OUT_W (%0d) must be >= IN_W (%0d)", OUT_W, IN_W);
    end
    for (genvar i = 0; i < DEPTH; i++) begin : g_lane
        arith_extend_lane #(.IN_W(IN_W), .OUT_W(OUT_W)) u_lane (
            .in   (in[i]),
            .sign (sign),
            .ext  (ext[i])
        );
    end
`ifdef ARITH_EXTEND_BYPASS_EN
    // extended values pass straight through with no latency
    always_comb out = ext;
`else
    // capture every lane each edge; reset zeroes all lanes and drops that edge's input
    always_ff @(posedge `CTRL_CLOCK(ctrl)) begin
        for (int i = 0; i < DEPTH; i++) out[i] <= `CTRL_RESET(ctrl) ? '0 : ext[i];
    end
`endif
endmodule

// File: tb/tb_arith_extend.sv
// tb_arith_extend: randomized and directed check of arith_extend against a value-level model
module tb_arith_extend;
    import Arith_pkg::*, Util_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    Control ctrl;
    logic [3:0] in_a [1:0];
    logic [3:0] in_b [0:0];
    SignedUnsigned sign = Signed;
    logic [7:0] out_a [1:0];
    logic [3:0] out_b [0:0];
    int vectors = 0;
    int errs = 0;
    bit done = 0;

    assign ctrl = '{clock: clk, reset: rst};
    always #5 clk = ~clk;

    arith_extend #(.IN_W(4), .OUT_W(8), .DEPTH(2)) dut_a (
        .ctrl (ctrl),
        .in   (in_a),
        .sign (sign),
        .out  (out_a)
    );
    arith_extend #(.IN_W(4), .OUT_W(4), .DEPTH(1)) dut_b (
        .ctrl (ctrl),
        .in   (in_b),
        .sign (sign),
        .out  (out_b)
    );

    function automatic longint model(longint v, int iw, int ow, bit s);
        longint r = v;
        if (s && r >= (64'sd1 << (iw - 1))) r -= (64'sd1 << iw);
        return r & ((64'sd1 << ow) - 1);
    endfunction

    task automatic chk(string name, longint act, longint exp);
        vectors++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // each edge: compute what the outputs must become from the sampled inputs, compare after settling
    always @(posedge clk) begin
        automatic longint e0, e1, e2;
        automatic bit s = (sign == Signed);
        e0 = rst ? 0 : model(longint'(in_a[0]), 4, 8, s);
        e1 = rst ? 0 : model(longint'(in_a[1]), 4, 8, s);
        e2 = rst ? 0 : model(longint'(in_b[0]), 4, 4, s);
        #1;
        if (!done) begin
            chk("model_lane0", longint'(out_a[0]), e0);
            chk("model_lane1", longint'(out_a[1]), e1);
            chk("model_eq_width", longint'(out_b[0]), e2);
        end
    end

    task automatic step(logic r, SignedUnsigned s, logic [3:0] a0, logic [3:0] a1);
        @(negedge clk);
        rst = r;
        sign = s;
        in_a[0] = a0;
        in_a[1] = a1;
        in_b[0] = a0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        in_a[0] = 4'h0;
        in_a[1] = 4'h0;
        in_b[0] = 4'h0;
        chk("pin_model_signed", model(64'hA, 4, 8, 1'b1), 64'hFA);
        chk("pin_model_unsigned", model(64'hA, 4, 8, 1'b0), 64'h0A);
        chk("pin_model_eq", model(64'h9, 4, 4, 1'b1), 64'h9);
        step(1'b1, Signed, 4'h0, 4'h0);
        chk("reset_l0", longint'(out_a[0]), 64'h00);
        chk("reset_l1", longint'(out_a[1]), 64'h00);
        @(negedge clk);
        rst = 1'b0;
        in_a[0] = 4'hA;
        in_a[1] = 4'h5;
        in_b[0] = 4'hA;
        #1;
        chk("hold_before_edge", longint'(out_a[0]), 64'h00);
        @(posedge clk);
        #1;
        chk("signed_A", longint'(out_a[0]), 64'hFA);
        chk("signed_5", longint'(out_a[1]), 64'h05);
        step(1'b0, Unsigned, 4'hA, 4'hF);
        chk("unsigned_A", longint'(out_a[0]), 64'h0A);
        chk("unsigned_F", longint'(out_a[1]), 64'h0F);
        step(1'b0, Signed, 4'h8, 4'h0);
        chk("signed_8", longint'(out_a[0]), 64'hF8);
        step(1'b0, Signed, 4'h0, 4'h0);
        chk("signed_0", longint'(out_a[0]), 64'h00);
        step(1'b0, Signed, 4'hA, 4'h5);
        chk("pre_reset_l0", longint'(out_a[0]), 64'hFA);
        step(1'b1, Signed, 4'hA, 4'h5);
        chk("mid_reset_l0", longint'(out_a[0]), 64'h00);
        chk("mid_reset_l1", longint'(out_a[1]), 64'h00);
        step(1'b0, Signed, 4'hA, 4'h5);
        chk("post_reset_l0", longint'(out_a[0]), 64'hFA);
        chk("post_reset_l1", longint'(out_a[1]), 64'h05);
        step(1'b0, Signed, 4'h9, 4'h0);
        chk("eq_width_9", longint'(out_b[0]), 64'h9);
        for (int k = 0; k < 300; k++)
            step($urandom_range(15) == 0, SignedUnsigned'($urandom_range(1)),
                 4'($urandom_range(15)), 4'($urandom_range(15)));
        done = 1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/arith_extend.md
Name: arith_extend

Overview:
- Parallel sign/zero extender with DEPTH independent lanes.
- Each lane widens an IN_W-bit value to OUT_W bits, using signed or unsigned extension as selected by a shared `sign` control.
- Outputs are registered: one-cycle latency, synchronous reset.
- Used in the datapath to widen immediates and narrow load data before the ALU and writeback.

Parameters:
- IN_W, 16, width of each input element (≥1).
- OUT_W, 32, width of each output element (≥ IN_W).
- DEPTH, 1, number of parallel lanes (≥1).

Ports:
- ctrl  input  Control struct  shared control bundle; `clock` field is the single clock (rising edge), `reset` field is synchronous active-high reset.
- in    input  [IN_W-1:0] x DEPTH (unpacked array, index DEPTH-1:0)  values to extend.
- sign  input  SignedUnsigned enum  Signed = replicate the input MSB; Unsigned = zero-fill. Applies to all lanes.
- out   output [OUT_W-1:0] x DEPTH (unpacked array, index DEPTH-1:0)  registered extended values.

Behaviour:
- Per lane i, combinational value:
  - Low bits: ext[i][IN_W-1:0] = in[i].
  - Upper bits ext[i][OUT_W-1:IN_W]: all equal to in[i][IN_W-1] when sign==Signed; all 0 when sign==Unsigned.
- OUT_W == IN_W: ext[i] = in[i]; `sign` has no effect.
- OUT_W < IN_W is illegal. Elaboration fails via $error in an initial/generate check.
- Register stage:
  - At each rising edge of ctrl.clock, out[i] <= ext[i].
  - Latency is exactly one clock; throughput is one set of values per clock.
- Reset:
  - When ctrl.reset==1 at a rising edge, every out[i] <= 0, regardless of `in` and `sign`.
  - Reset is synchronous only; no asynchronous path.
  - Reset asserted mid-stream discards the value being captured that edge.
  - The first capture after deassertion is the `in`/`sign` value present at that edge.
- `sign` is sampled on the same edge as `in`. A change of `sign` affects only the values captured at that edge.
- Lanes are fully independent; no cross-lane interaction.
- No handshake: the block is always ready and always valid after reset.
- X on an `in` element propagates only to that lane.

Optional Feature:
- Macro: ARITH_EXTEND_BYPASS_EN.
- Defined: the register stage is removed. out[i] = ext[i] combinationally (zero latency), ctrl.reset is ignored, and there is no reset value.
- Undefined (default): registered behaviour with one-cycle latency and synchronous reset, as described above.

Decomposition:
- Shared package Arith_pkg holds:
  - SignedUnsigned enum: Unsigned=0, Signed=1, 1 bit.
- Shared package Util_pkg holds:
  - Control struct with fields `clock` and `reset`, plus accessor macros.
- Sub-module arith_extend_lane:
  - Single-element combinational extender with parameters IN_W and OUT_W; inputs in and sign, output ext.
  - Instantiated DEPTH times in a generate loop.
  - The parent holds the output register array and the parameter legality check.

Test Plan:
1. IN_W=4, OUT_W=8, DEPTH=2, sign=Signed, reset held for 1 clock with in={0,0} -> out[0]=out[1]=8'h00 during and after reset.
2. Signed, in[0]=4'hA, in[1]=4'h5 applied before edge N -> after edge N: out[0]=8'hFA, out[1]=8'h05. Before edge N, out still holds the previous value (8'h00).
3. Unsigned, in[0]=4'hA, in[1]=4'hF -> next cycle: out[0]=8'h0A, out[1]=8'h0F.
4. Signed with in[0]=4'h8 then in[0]=4'h0 on consecutive cycles -> out[0] is 8'hF8 then 8'h00. Confirms one-cycle latency and full throughput.
5. With outputs at 8'hFA/8'h05, assert reset for one edge while in stays 4'hA/4'h5 -> out=8'h00/8'h00 at that edge. After deassertion, the next edge gives 8'hFA/8'h05.
6. OUT_W=IN_W=4, Signed, in=4'h9 -> out=4'h9. Repeat with ARITH_EXTEND_BYPASS_EN defined -> Signed in=4'hA gives out=8'hFA in the same cycle.
